// File: rtl/execute_stage_mc.sv
// EX stage + EX/MEM register with an iterative shift-add multiplier.
// Define EXEC_FWD_EN to add M/W operand forwarding ports.
module execute_stage_mc #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5,
  parameter int STRW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validE,
  input  logic             flushE,
  input  logic             stallM,
  output logic             busyE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             MemtoRegE,
  input  logic             PCBranchE,
  input  logic [STRW-1:0]  strCtrlE,
  input  logic [3:0]       ALUopE,
  input  logic [1:0]       SrcASelE,
  input  logic             SrcBSelE,
  input  logic [XLEN-1:0]  immE,
  input  logic [XLEN-1:0]  PCE,
  input  logic [XLEN-1:0]  r1E,
  input  logic [XLEN-1:0]  r2E,
  input  logic [RADDR-1:0] rdE,
`ifdef EXEC_FWD_EN
  input  logic [RADDR-1:0] rs1E,
  input  logic [RADDR-1:0] rs2E,
  input  logic [XLEN-1:0]  resultW,
  input  logic [RADDR-1:0] rdW,
  input  logic             RegWriteW,
`endif
  output logic             validM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             MemtoRegM,
  output logic             PCBranchM,
  output logic             branchM,
  output logic [STRW-1:0]  strCtrlM,
  output logic [RADDR-1:0] rdM,
  output logic [XLEN-1:0]  ALUoutM,
  output logic [XLEN-1:0]  PCplusImmM,
  output logic [XLEN-1:0]  r2M
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;

  logic                valid_q, valid_d;
  logic                regw_q, regw_d;
  logic                memw_q, memw_d;
  logic                m2r_q, m2r_d;
  logic                pcb_q, pcb_d;
  logic                br_q, br_d;
  logic [STRW-1:0]     str_q, str_d;
  logic [RADDR-1:0]    rd_q, rd_d;
  logic [XLEN-1:0]     alu_q, alu_d;
  logic [XLEN-1:0]     pci_q, pci_d;
  logic [XLEN-1:0]     r2_q, r2_d;

  logic [XLEN-1:0]     fr1, fr2, a, b, alu;
  logic [SHW-1:0]      shamt;
  logic                is_mul, bubble;

`ifdef EXEC_FWD_EN
  logic fwd_m;
  assign fwd_m = valid_q & regw_q & ~m2r_q;
  assign fr1 =
    (fwd_m && rd_q == rs1E && rs1E != '0) ? alu_q :
    (RegWriteW && rdW == rs1E && rs1E != '0) ? resultW :
    r1E;
  assign fr2 =
    (fwd_m && rd_q == rs2E && rs2E != '0) ? alu_q :
    (RegWriteW && rdW == rs2E && rs2E != '0) ? resultW :
    r2E;
`else
  assign fr1 = r1E;
  assign fr2 = r2E;
`endif

  assign is_mul = (ALUopE == 4'd10) || (ALUopE == 4'd11);
  assign shamt  = b[SHW-1:0];

  always_comb begin
    unique case (SrcASelE)
      2'd0:    a = fr1;
      2'd1:    a = PCE;
      default: a = '0;
    endcase
    b = SrcBSelE ? immE : fr2;
    case (ALUopE)
      4'd0:    alu = a + b;
      4'd1:    alu = a - b;
      4'd2:    alu = a << shamt;
      4'd3:    alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd4:    alu = {{(XLEN-1){1'b0}}, a < b};
      4'd5:    alu = a ^ b;
      4'd6:    alu = a >> shamt;
      4'd7:    alu = $signed(a) >>> shamt;
      4'd8:    alu = a | b;
      4'd9:    alu = a & b;
      4'd10:   alu = acc_q[XLEN-1:0];
      4'd11:   alu = acc_q[2*XLEN-1:XLEN];
      default: alu = '0;
    endcase
  end

  // busyE depends on this cycle's E/M inputs, so it stays combinational
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    busyE    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (validE && !flushE && is_mul) begin
          busyE    = 1'b1;
          state_d  = BUSY;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, fr1};
          mplier_d = fr2;
        end
      end
      BUSY: begin
        busyE = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN-1)) state_d = DONE;
      end
      DONE: begin
        busyE = stallM;
        if (!stallM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flushE) state_d = IDLE;
  end

  assign bubble = !validE || flushE || busyE;

  always_comb begin
    valid_d = valid_q;
    regw_d  = regw_q;
    memw_d  = memw_q;
    m2r_d   = m2r_q;
    pcb_d   = pcb_q;
    br_d    = br_q;
    str_d   = str_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    pci_d   = pci_q;
    r2_d    = r2_q;
    if (!stallM) begin
      valid_d = !bubble;
      regw_d  = !bubble && RegWriteE;
      memw_d  = !bubble && MemWriteE;
      m2r_d   = !bubble && MemtoRegE;
      pcb_d   = !bubble && PCBranchE;
      br_d    = !bubble && PCBranchE && (alu != '0);
      str_d   = bubble ? '0 : strCtrlE;
      rd_d    = rdE;
      alu_d   = alu;
      pci_d   = PCE + immE;
      r2_d    = fr2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      valid_q  <= 1'b0;
      regw_q   <= 1'b0;
      memw_q   <= 1'b0;
      m2r_q    <= 1'b0;
      pcb_q    <= 1'b0;
      br_q     <= 1'b0;
      str_q    <= '0;
      rd_q     <= '0;
      alu_q    <= '0;
      pci_q    <= '0;
      r2_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      valid_q  <= valid_d;
      regw_q   <= regw_d;
      memw_q   <= memw_d;
      m2r_q    <= m2r_d;
      pcb_q    <= pcb_d;
      br_q     <= br_d;
      str_q    <= str_d;
      rd_q     <= rd_d;
      alu_q    <= alu_d;
      pci_q    <= pci_d;
      r2_q     <= r2_d;
    end
  end

  assign validM     = valid_q;
  assign RegWriteM  = regw_q;
  assign MemWriteM  = memw_q;
  assign MemtoRegM  = m2r_q;
  assign PCBranchM  = pcb_q;
  assign branchM    = br_q;
  assign strCtrlM   = str_q;
  assign rdM        = rd_q;
  assign ALUoutM    = alu_q;
  assign PCplusImmM = pci_q;
  assign r2M        = r2_q;
endmodule
